// File: rtl/reg_op_seq.sv
// Multi-cycle register-to-register operation sequencer driving an 8x8 register file port.
// Optional saturating arithmetic is enabled by defining REG_OP_SAT_EN.
module reg_op_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rf_load,
    output logic [AW-1:0]    rf_sel,
    output logic [WIDTH-1:0] rf_d,
    input  logic [WIDTH-1:0] rf_q,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             done
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q, op_nx;
    logic [AW-1:0]    rd_q, rd_nx;
    logic [AW-1:0]    rs2_q, rs2_nx;
    logic [WIDTH-1:0] imm_q, imm_nx;
    logic [WIDTH-1:0] opa_q, opa_nx;
    logic [WIDTH-1:0] opb_q, opb_nx;
    logic [WIDTH-1:0] result_nx;
    logic             z_nx, c_nx;
    logic             ready_nx, load_nx, done_nx;
    logic [AW-1:0]    sel_nx;
    logic [WIDTH-1:0] d_nx;

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    // ALU on the latched operands and command
    always_comb begin
        alu_sum = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
`ifdef REG_OP_SAT_EN
                if (alu_sum[WIDTH]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res = opa_q - opb_q;
                alu_c   = (opa_q < opb_q);
`ifdef REG_OP_SAT_EN
                if (opa_q < opb_q) alu_res = '0;
`endif
            end
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_LDI:  alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    // Next state and next registered outputs; rs1 is consumed straight into rf_sel at accept
    always_comb begin
        state_nx  = state;
        op_nx     = op_q;
        rd_nx     = rd_q;
        rs2_nx    = rs2_q;
        imm_nx    = imm_q;
        opa_nx    = opa_q;
        opb_nx    = opb_q;
        result_nx = result;
        z_nx      = flag_z;
        c_nx      = flag_c;
        load_nx   = 1'b0;
        sel_nx    = '0;
        d_nx      = '0;
        done_nx   = 1'b0;
        ready_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nx  = cmd_op;
                    rd_nx  = cmd_rd;
                    rs2_nx = cmd_rs2;
                    imm_nx = cmd_imm;
                    if (cmd_op == OP_LDI) begin
                        state_nx = EXEC;
                    end else begin
                        state_nx = RD_A;
                        sel_nx   = cmd_rs1;
                    end
                end
            end
            RD_A: begin
                opa_nx   = rf_q;
                sel_nx   = rs2_q;
                state_nx = RD_B;
            end
            RD_B: begin
                opb_nx   = rf_q;
                state_nx = EXEC;
            end
            EXEC: begin
                result_nx = alu_res;
                z_nx      = (alu_res == '0);
                c_nx      = alu_c;
                load_nx   = 1'b1;
                sel_nx    = rd_q;
                d_nx      = alu_res;
                state_nx  = WB;
            end
            WB: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            cmd_ready <= 1'b1;
            rf_load   <= 1'b0;
            rf_sel    <= '0;
            rf_d      <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            rd_q      <= rd_nx;
            rs2_q     <= rs2_nx;
            imm_q     <= imm_nx;
            opa_q     <= opa_nx;
            opb_q     <= opb_nx;
            result    <= result_nx;
            flag_z    <= z_nx;
            flag_c    <= c_nx;
            cmd_ready <= ready_nx;
            rf_load   <= load_nx;
            rf_sel    <= sel_nx;
            rf_d      <= d_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_reg_op_seq.sv
// Self-checking bench for reg_op_seq with a behavioural 8x8 register file attached.
module tb_reg_op_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 3;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [AW-1:0]    cmd_rd = '0;
    logic [AW-1:0]    cmd_rs1 = '0;
    logic [AW-1:0]    cmd_rs2 = '0;
    logic [WIDTH-1:0] cmd_imm = '0;
    logic             rf_load;
    logic [AW-1:0]    rf_sel;
    logic [WIDTH-1:0] rf_d;
    logic [WIDTH-1:0] rf_q;
    logic [WIDTH-1:0] result;
    logic             flag_z, flag_c, done;

    logic [WIDTH-1:0] rf [8];

    reg_op_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_load(rf_load), .rf_sel(rf_sel), .rf_d(rf_d), .rf_q(rf_q),
        .result(result), .flag_z(flag_z), .flag_c(flag_c), .done(done)
    );

    always #5 clk = ~clk;

    assign rf_q = rf[rf_sel];
    always @(posedge clk) if (rf_load) rf[rf_sel] <= rf_d;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [AW-1:0]    rd, rs1, rs2;
        logic [WIDTH-1:0] imm, res;
        logic             z, c;
        int               lat;
        bit               hold;
    } vec_t;

    vec_t vecs[8];

    // Issue one command, track the handshake through done, then compare the outcome
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, loads, load_cyc, sel1, selwb, busy_ready;
        bit seen;
        @(negedge clk);
        check($sformatf("v%0d ready_before", idx), 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1; cmd_op = v.op; cmd_rd = v.rd;
        cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_imm = v.imm;
        @(posedge clk); #1;
        if (!v.hold) cmd_valid = 1'b0;
        else begin
            cmd_op = OP_LDI; cmd_rd = 3'd5; cmd_imm = 8'hAA;
            cmd_rs1 = 3'd6; cmd_rs2 = 3'd6;
        end
        cyc = 1; loads = 0; load_cyc = -1; sel1 = -1; selwb = -1; busy_ready = 0; seen = 0;
        while (cyc <= 12 && !seen) begin
            if (cyc == 1) begin sel1 = int'(rf_sel); busy_ready = int'(cmd_ready); end
            if (rf_load) begin loads++; load_cyc = cyc; selwb = int'(rf_sel); end
            if (done) begin
                seen = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check($sformatf("v%0d done_latency", idx), 32'(seen ? cyc : -1), 32'(v.lat));
        check($sformatf("v%0d busy_ready", idx), 32'(busy_ready), 32'(0));
        check($sformatf("v%0d load_count", idx), 32'(loads), 32'(1));
        check($sformatf("v%0d load_cycle", idx), 32'(load_cyc), 32'(v.lat - 1));
        check($sformatf("v%0d wb_sel", idx), 32'(selwb), 32'(v.rd));
        if (v.op != OP_LDI) check($sformatf("v%0d rd_a_sel", idx), 32'(sel1), 32'(v.rs1));
        check($sformatf("v%0d result", idx), 32'(result), 32'(v.res));
        check($sformatf("v%0d flag_z", idx), 32'(flag_z), 32'(v.z));
        check($sformatf("v%0d flag_c", idx), 32'(flag_c), 32'(v.c));
        check($sformatf("v%0d rf_rd", idx), 32'(rf[v.rd]), 32'(v.res));
        if (v.hold) begin
            @(posedge clk); #1;
            check($sformatf("v%0d no_extra_done", idx), 32'(done), 32'(0));
            check($sformatf("v%0d no_extra_accept", idx), 32'(cmd_ready), 32'(1));
        end
    endtask

    // Start ADD rd=3, pull reset in the given busy cycle, confirm the command is dropped
    task automatic abort_at(input int at_cyc, input string tag);
        int dones;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs1 = 3'd2; cmd_rs2 = 3'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i < at_cyc; i++) begin
            @(posedge clk); #1;
        end
        if (at_cyc == 4) check({tag, " in_wb"}, 32'(rf_load), 32'(1));
        #2 reset = 1'b0;
        #1;
        check({tag, " ready"}, 32'(cmd_ready), 32'(1));
        check({tag, " load"}, 32'(rf_load), 32'(0));
        check({tag, " sel"}, 32'(rf_sel), 32'(0));
        check({tag, " result"}, 32'(result), 32'(0));
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check({tag, " no_done"}, 32'(dones), 32'(0));
        check({tag, " r3_kept"}, 32'(rf[3]), 32'(8'h38));
    endtask

    initial begin
        int cyc;
        bit seen;

        vecs[0] = '{OP_LDI, 3'd1, 3'd0, 3'd0, 8'h25, 8'h25, 1'b0, 1'b0, 3, 1'b0};
        vecs[1] = '{OP_LDI, 3'd2, 3'd0, 3'd0, 8'h13, 8'h13, 1'b0, 1'b0, 3, 1'b0};
        vecs[2] = '{OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h38, 1'b0, 1'b0, 5, 1'b0};
        vecs[3] = '{OP_LDI, 3'd4, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 3, 1'b0};
        vecs[4] = '{OP_LDI, 3'd5, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 1'b0, 3, 1'b0};
`ifdef REG_OP_SAT_EN
        vecs[5] = '{OP_ADD, 3'd6, 3'd4, 3'd5, 8'h00, 8'hFF, 1'b0, 1'b1, 5, 1'b0};
        vecs[6] = '{OP_SUB, 3'd7, 3'd2, 3'd1, 8'h00, 8'h00, 1'b1, 1'b1, 5, 1'b0};
`else
        vecs[5] = '{OP_ADD, 3'd6, 3'd4, 3'd5, 8'h00, 8'h10, 1'b0, 1'b1, 5, 1'b0};
        vecs[6] = '{OP_SUB, 3'd7, 3'd2, 3'd1, 8'h00, 8'hEE, 1'b0, 1'b1, 5, 1'b0};
`endif
        vecs[7] = '{OP_XOR, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 5, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(cmd_ready), 32'(1));
        check("reset load", 32'(rf_load), 32'(0));
        check("reset sel_d", 32'({rf_sel, rf_d}), 32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset flags_done", 32'({flag_z, flag_c, done}), 32'(0));
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
        check("r2 after xor", 32'(rf[2]), 32'(8'h13));

        abort_at(2, "abort_rd_b");
        abort_at(4, "abort_wb");

        // Back-to-back: LDI r4=0x5A, then ADD r5=r4+r2 accepted on the done edge
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LDI; cmd_rd = 3'd4; cmd_imm = 8'h5A;
        @(posedge clk); #1;
        cmd_op = OP_ADD; cmd_rd = 3'd5; cmd_rs1 = 3'd4; cmd_rs2 = 3'd2; cmd_imm = 8'h00;
        cyc = 1; seen = 0;
        while (cyc <= 12 && !seen) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check("b2b first_latency", 32'(seen ? cyc : -1), 32'(3));
        check("b2b ready_in_done", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b second_accepted", 32'(cmd_ready), 32'(0));
        check("b2b rd_a_sel", 32'(rf_sel), 32'(4));
        cyc = 1; seen = 0;
        while (cyc <= 12 && !seen) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check("b2b second_latency", 32'(seen ? cyc : -1), 32'(5));
        check("b2b r4", 32'(rf[4]), 32'(8'h5A));
        check("b2b r5", 32'(rf[5]), 32'(8'h6D));
        check("b2b flags", 32'({flag_z, flag_c}), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_op_seq.md
Name: reg_op_seq

Overview:
- Multi-cycle operation sequencer that sits directly upstream of the 8x8 register file.
- Drives the file's single load/sel/d port and consumes its q output.
- Accepts one register-to-register command per handshake: read rs1, read rs2, compute, write back to rd. Returns flags and a done pulse.
- Register file reads are combinational on sel; writes land on the clk edge when load=1.

Parameters:
- WIDTH, 8, data width of rf_d, rf_q, cmd_imm and result.
- AW, 3, register address width (2^AW registers).

Ports:
- clk  in  1  system clock; rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 XOR, 11 LDI
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  source A
- cmd_rs2  in  AW  source B
- cmd_imm  in  WIDTH  immediate value for LDI
- rf_load  out  1  write enable to register file
- rf_sel  out  AW  read/write select to register file
- rf_d  out  WIDTH  write data to register file
- rf_q  in  WIDTH  read data from register file
- result  out  WIDTH  last computed value
- flag_z  out  1  result == 0
- flag_c  out  1  ADD carry-out / SUB borrow
- done  out  1  one-cycle pulse: write-back completed

Behaviour:
- States: IDLE, RD_A, RD_B, EXEC, WB.
- Reset (reset=0, asynchronous) forces these values immediately:
  - state=IDLE, cmd_ready=1, rf_load=0, rf_sel=0, rf_d=0
  - result=0, flag_z=0, flag_c=0, done=0
  - internal opA/opB/latched command=0
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, latch all cmd_* fields. Next state is RD_A, or EXEC when op=LDI.
- RD_A: rf_sel=rs1; capture rf_q into opA at the edge; go to RD_B.
- RD_B: rf_sel=rs2; capture rf_q into opB at the edge; go to EXEC.
- EXEC: register result and flags at the edge; go to WB. Operations:
  - ADD: {c,result}=opA+opB
  - SUB: result=opA-opB, c=(opA<opB)
  - XOR: c=0
  - LDI: result=imm, c=0
  - All ops: z=(result==0)
- WB: rf_sel=rd, rf_load=1, rf_d=result. The write lands at the end edge; go to IDLE with done=1 for exactly one cycle.
- Latency from the accept edge:
  - Reg ops: WB in cycle 4, done in cycle 5.
  - LDI: WB in cycle 2, done in cycle 3.
- Back-to-back operation: in the done cycle cmd_ready=1, so a new command can be accepted on that same edge.
- cmd_ready=0 in every state except IDLE. cmd_valid is ignored while busy, and cmd_* fields are not re-sampled.
- rf_load is high only in WB. rf_sel=0 and rf_d=0 in IDLE.
- rd may equal rs1 and/or rs2; reads always precede the write. rs1==rs2 is legal.
- Arithmetic is modulo 2^WIDTH unless the optional feature is enabled.
- result and flags hold between commands.
- Reset asserted mid-operation aborts the command. No write occurs, even if reset is asserted during WB before the edge. done stays 0.

Optional Feature:
- Macro: REG_OP_SAT_EN.
- Defined:
  - ADD overflow gives result=all-ones (0xFF) with c=1.
  - SUB borrow gives result=0 with c=1 and z=1.
- Undefined: wrap-around arithmetic as above. All other behaviour is identical.

Test Plan:
- Reset, then LDI rd=1 imm=0x25, then LDI rd=2 imm=0x13 -> each done 2 cycles after accept; file reads r1=0x25, r2=0x13.
- ADD rd=3 rs1=1 rs2=2 -> rf_sel sequence 1,2,–,3; rf_load high one cycle; r3=0x38, z=0, c=0; done 4 cycles after accept.
- LDI r4=0xF0, r5=0x20; ADD rd=6 rs1=4 rs2=5 -> r6=0x10, c=1 (0xFF with REG_OP_SAT_EN). SUB rd=7 rs1=2 rs2=1 -> r7=0xEE, c=1 (0x00, z=1 with REG_OP_SAT_EN).
- XOR rd=1 rs1=1 rs2=1 -> r1=0x00, z=1, c=0. Hold cmd_valid=1 during the busy cycles -> no extra accept, exactly one done.
- Assert reset=0 during RD_B of ADD rd=3 -> state IDLE, rf_load=0 immediately, r3 unchanged, no done.
- Two commands with cmd_valid held high -> second accepted on the done edge; no idle gap.
